// File: rtl/bw_iodll_pkg.sv
// Shared types and defaults for the DDR master-DLL lock/tracking controller.
package bw_iodll_pkg;

  localparam int CODE_W_DEF   = 5;
  localparam int FILT_W_DEF   = 4;
  localparam int SETTLE_DEF   = 8;
  localparam int LOCK_CNT_DEF = 32;

  typedef enum logic [1:0] {
    SETTLING = 2'd0,
    ACQ      = 2'd1,
    LOCKED   = 2'd2,
    BYP      = 2'd3
  } dll_state_e;

  // Mid-scale delay code for a given code width (the power-up delay setting).
  function automatic int code_mid(input int w);
    return 1 << (w - 1);
  endfunction

  localparam logic [CODE_W_DEF-1:0] CODE_MID = CODE_W_DEF'(code_mid(CODE_W_DEF));

endpackage

// File: rtl/bw_iodll_lock_ctl_if.sv
// Phase-detector / delay-line signal bundle for the DDR DLL lock controller.
interface bw_iodll_lock_ctl_if #(
  parameter int CODE_W = 5
);
  logic              io_dll_bypass_l;
  logic [CODE_W-1:0] bypass_data;
  logic              pd_valid;
  logic              pd_up;
  logic [CODE_W-1:0] lpf_out;
  logic              iodll_lock;
  logic              overflow;
  logic              strobe;

  modport master (
    output io_dll_bypass_l, bypass_data, pd_valid, pd_up,
    input  lpf_out, iodll_lock, overflow, strobe
  );

  modport slave (
    input  io_dll_bypass_l, bypass_data, pd_valid, pd_up,
    output lpf_out, iodll_lock, overflow, strobe
  );
endinterface

// File: rtl/bw_iodll_lpf.sv
// Vote accumulator feeding a saturating delay-code counter with a sticky overflow flag.
module bw_iodll_lpf #(
  parameter int                CODE_W   = 5,
  parameter int                FILT_W   = 4,
  parameter logic [CODE_W-1:0] CODE_RST = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vote_en,
  input  logic              vote_up,
  input  logic              acc_clr,
  input  logic              load_en,
  input  logic [CODE_W-1:0] load_val,
  output logic [CODE_W-1:0] code,
  output logic              step_up,
  output logic              step_dn,
  output logic              sat,
  output logic              overflow
);
  localparam logic signed [FILT_W-1:0] ACC_HI  = FILT_W'((1 << (FILT_W - 1)) - 1);
  localparam logic signed [FILT_W-1:0] ACC_LO  = FILT_W'(1 << (FILT_W - 1));
  localparam logic signed [FILT_W-1:0] ACC_ONE = FILT_W'(1);

  logic signed [FILT_W-1:0] acc_reg;
  logic signed [FILT_W-1:0] acc_next;
  logic [CODE_W-1:0]        code_reg;
  logic                     ovf_reg;
  logic                     at_max;
  logic                     at_min;

  // The accumulator is cleared on every threshold hit, so it never wraps.
  assign acc_next = vote_up ? (acc_reg + ACC_ONE) : (acc_reg - ACC_ONE);
  assign step_up  = vote_en &  vote_up & (acc_next == ACC_HI);
  assign step_dn  = vote_en & ~vote_up & (acc_next == ACC_LO);
  assign at_max   = &code_reg;
  assign at_min   = ~|code_reg;
  assign sat      = (step_up & at_max) | (step_dn & at_min);
  assign code     = code_reg;
  assign overflow = ovf_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg  <= '0;
      code_reg <= CODE_RST;
      ovf_reg  <= 1'b0;
    end else begin
      if (load_en)
        code_reg <= load_val;
      else if (step_up && !at_max)
        code_reg <= code_reg + 1'b1;
      else if (step_dn && !at_min)
        code_reg <= code_reg - 1'b1;

      if (sat)
        ovf_reg <= 1'b1;

      if (acc_clr || step_up || step_dn)
        acc_reg <= '0;
      else if (vote_en)
        acc_reg <= acc_next;
    end
  end
endmodule

// File: rtl/bw_iodll_lock_ctl.sv
// Master DDR DLL lock controller: settle/lock FSM, bypass mux and strobe around the code filter.
module bw_iodll_lock_ctl
  import bw_iodll_pkg::*;
#(
  parameter int CODE_W   = CODE_W_DEF,
  parameter int FILT_W   = FILT_W_DEF,
  parameter int SETTLE   = SETTLE_DEF,
  parameter int LOCK_CNT = LOCK_CNT_DEF
) (
  input  logic               ddr_clk_in,
  input  logic               io_dll_reset,
  bw_iodll_lock_ctl_if.slave dll
);
  localparam int                SETTLE_W = $clog2(SETTLE + 1);
  localparam int                LOCK_W   = $clog2(LOCK_CNT + 1);
  localparam logic [CODE_W-1:0] MID      = CODE_W'(code_mid(CODE_W));

  dll_state_e        state_reg;
  dll_state_e        ret_reg;
  logic [SETTLE_W-1:0] settle_reg;
  logic [LOCK_W-1:0]   lock_cnt_reg;
  logic              lock_reg;
  logic              strobe_reg;
  logic              last_dir_vld_reg;
  logic              last_dir_reg;

  logic              bypass;
  logic              tracking;
  logic              vote_en;
  logic              step_up;
  logic              step_dn;
  logic              step;
  logic              sat;
  logic [CODE_W-1:0] code;

  assign bypass   = ~dll.io_dll_bypass_l;
  assign tracking = (state_reg == ACQ) || (state_reg == LOCKED);
  assign vote_en  = tracking & dll.pd_valid & ~bypass;
  assign step     = step_up | step_dn;

  bw_iodll_lpf #(
    .CODE_W   (CODE_W),
    .FILT_W   (FILT_W),
    .CODE_RST (MID)
  ) u_lpf (
    .clk      (ddr_clk_in),
    .rst      (io_dll_reset),
    .vote_en  (vote_en),
    .vote_up  (dll.pd_up),
    .acc_clr  (bypass),
    .load_en  (bypass),
    .load_val (dll.bypass_data),
    .code     (code),
    .step_up  (step_up),
    .step_dn  (step_dn),
    .sat      (sat),
    .overflow (dll.overflow)
  );

  assign dll.lpf_out    = code;
  assign dll.iodll_lock = lock_reg;
  assign dll.strobe     = strobe_reg;

  always_ff @(posedge ddr_clk_in or posedge io_dll_reset) begin
    if (io_dll_reset) begin
      state_reg        <= SETTLING;
      ret_reg          <= ACQ;
      settle_reg       <= SETTLE_W'(SETTLE);
      lock_cnt_reg     <= '0;
      lock_reg         <= 1'b0;
      strobe_reg       <= 1'b0;
      last_dir_vld_reg <= 1'b0;
      last_dir_reg     <= 1'b0;
    end else begin
      // A saturated step leaves the code untouched, so it raises no strobe.
      strobe_reg <= step & ~sat;
      if (bypass) begin
        state_reg    <= BYP;
        lock_reg     <= 1'b0;
        lock_cnt_reg <= '0;
        strobe_reg   <= (dll.bypass_data != code);
      end else begin
        case (state_reg)
          BYP: begin
            state_reg  <= SETTLING;
            ret_reg    <= ACQ;
            settle_reg <= SETTLE_W'(SETTLE);
          end
          SETTLING: begin
            if (settle_reg <= SETTLE_W'(1)) begin
              state_reg  <= ret_reg;
              settle_reg <= '0;
            end else begin
              settle_reg <= settle_reg - 1'b1;
            end
          end
          ACQ: begin
            if (step) begin
              state_reg    <= SETTLING;
              ret_reg      <= ACQ;
              settle_reg   <= SETTLE_W'(SETTLE);
              lock_cnt_reg <= '0;
            end else if (dll.pd_valid) begin
              if (lock_cnt_reg == LOCK_W'(LOCK_CNT - 1)) begin
                state_reg        <= LOCKED;
                lock_reg         <= 1'b1;
                last_dir_vld_reg <= 1'b0;
                lock_cnt_reg     <= LOCK_W'(LOCK_CNT);
              end else if (lock_cnt_reg < LOCK_W'(LOCK_CNT)) begin
                lock_cnt_reg <= lock_cnt_reg + 1'b1;
              end
            end
          end
          LOCKED: begin
            if (step) begin
              state_reg    <= SETTLING;
              settle_reg   <= SETTLE_W'(SETTLE);
              lock_cnt_reg <= '0;
              // Two steps in a row the same way means the loop has walked off; drop lock.
              if (last_dir_vld_reg && (last_dir_reg == step_up)) begin
                lock_reg         <= 1'b0;
                ret_reg          <= ACQ;
                last_dir_vld_reg <= 1'b0;
              end else begin
                ret_reg          <= LOCKED;
                last_dir_vld_reg <= 1'b1;
                last_dir_reg     <= step_up;
              end
            end
          end
          default: state_reg <= SETTLING;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_bw_iodll_lock_ctl.sv
// Scoreboard bench for bw_iodll_lock_ctl: a behavioural model predicts each cycle's outputs.
module tb_bw_iodll_lock_ctl;
  localparam int SETTLE   = 8;
  localparam int LOCK_CNT = 32;
  localparam int M_SET = 0, M_ACQ = 1, M_LCK = 2, M_BYP = 3;

  typedef struct packed {
    logic [4:0] code;
    logic       lock;
    logic       ovf;
    logic       stb;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bw_iodll_lock_ctl_if #(.CODE_W(5)) dll ();

  bw_iodll_lock_ctl dut (
    .ddr_clk_in   (clk),
    .io_dll_reset (rst),
    .dll          (dll)
  );

  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  exp_t sb_q[$];

  // Behavioural reference state
  int m_state, m_ret, m_settle, m_lock_cnt, m_acc, m_code, m_lastdir;
  bit m_lock, m_ovf, m_stb;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", tag, got, exp, cyc, $time);
    end
  endtask

  task automatic model_reset();
    m_state = M_SET; m_ret = M_ACQ; m_settle = SETTLE; m_lock_cnt = 0;
    m_acc = 0; m_code = 16; m_lastdir = -1;
    m_lock = 0; m_ovf = 0; m_stb = 0;
    sb_q.delete();
  endtask

  // Predict the outputs after the coming clock edge from the inputs now being driven.
  task automatic model_step();
    int  a;
    bit  up;
    exp_t e;
    m_stb = 0;
    if (!dll.io_dll_bypass_l) begin
      m_stb = (int'(dll.bypass_data) != m_code);
      m_code = int'(dll.bypass_data);
      m_lock = 0; m_lock_cnt = 0; m_acc = 0; m_state = M_BYP;
    end else begin
      case (m_state)
        M_BYP: begin
          m_state = M_SET; m_ret = M_ACQ; m_settle = SETTLE;
        end
        M_SET: begin
          m_settle--;
          if (m_settle == 0) m_state = m_ret;
        end
        default: begin
          if (dll.pd_valid) begin
            a = m_acc + (dll.pd_up ? 1 : -1);
            if (a == 7 || a == -8) begin
              up = (a == 7);
              if ((up && m_code == 31) || (!up && m_code == 0)) m_ovf = 1;
              else begin
                m_code = m_code + (up ? 1 : -1);
                m_stb = 1;
              end
              m_acc = 0; m_lock_cnt = 0; m_settle = SETTLE;
              if (m_state == M_LCK) begin
                if (m_lastdir == int'(up)) begin
                  m_lock = 0; m_ret = M_ACQ; m_lastdir = -1;
                end else begin
                  m_ret = M_LCK; m_lastdir = int'(up);
                end
              end else begin
                m_ret = M_ACQ;
              end
              m_state = M_SET;
            end else begin
              m_acc = a;
              if (m_state == M_ACQ) begin
                m_lock_cnt++;
                if (m_lock_cnt == LOCK_CNT) begin
                  m_state = M_LCK; m_lock = 1; m_lastdir = -1;
                end
              end
            end
          end
        end
      endcase
    end
    e.code = 5'(m_code); e.lock = m_lock; e.ovf = m_ovf; e.stb = m_stb;
    sb_q.push_back(e);
  endtask

  task automatic cycle();
    exp_t e;
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'(sb_q.size()), 32'd1);
    end else begin
      e = sb_q.pop_front();
      check("lpf_out", 32'(dll.lpf_out), 32'(e.code));
      check("iodll_lock", 32'(dll.iodll_lock), 32'(e.lock));
      check("overflow", 32'(dll.overflow), 32'(e.ovf));
      check("strobe", 32'(dll.strobe), 32'(e.stb));
    end
    $display("cyc %0d bl=%0b bd=%02h v=%0b up=%0b -> lpf=%02h lock=%0b ovf=%0b stb=%0b",
             cyc, dll.io_dll_bypass_l, dll.bypass_data, dll.pd_valid, dll.pd_up,
             dll.lpf_out, dll.iodll_lock, dll.overflow, dll.strobe);
  endtask

  task automatic drive(input bit bl, input logic [4:0] bd, input bit v, input bit up, input int n);
    dll.io_dll_bypass_l = bl;
    dll.bypass_data     = bd;
    dll.pd_valid        = v;
    dll.pd_up           = up;
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Asynchronous reset placed between clock edges; outputs must follow without a clock.
  task automatic apply_reset(input string tag);
    #3 rst = 1'b1;
    #1;
    check({tag, "_lpf"}, 32'(dll.lpf_out), 32'h10);
    check({tag, "_lock"}, 32'(dll.iodll_lock), 32'd0);
    check({tag, "_ovf"}, 32'(dll.overflow), 32'd0);
    check({tag, "_stb"}, 32'(dll.strobe), 32'd0);
    $display("reset %s at t=%0t", tag, $time);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic alt_to_lock();
    for (int i = 0; i < 40; i++) drive(1'b1, 5'h00, 1'b1, (i % 2) == 0, 1);
  endtask

  initial begin
    dll.io_dll_bypass_l = 1'b1;
    dll.bypass_data     = 5'h00;
    dll.pd_valid        = 1'b0;
    dll.pd_up           = 1'b0;
    model_reset();
    apply_reset("init");

    // Continuous up votes: first step after settle + 7 votes, next one a full period later
    drive(1'b1, 5'h00, 1'b1, 1'b1, 14);
    check("t1_pre_step", 32'(dll.lpf_out), 32'h10);
    drive(1'b1, 5'h00, 1'b1, 1'b1, 1);
    check("t1_step1", 32'(dll.lpf_out), 32'h11);
    check("t1_stb1", 32'(dll.strobe), 32'd1);
    drive(1'b1, 5'h00, 1'b1, 1'b1, 15);
    check("t1_step2", 32'(dll.lpf_out), 32'h12);
    apply_reset("after_strobe");

    // Alternating votes lock without stepping, then two same-way steps drop lock
    for (int i = 0; i < 39; i++) drive(1'b1, 5'h00, 1'b1, (i % 2) == 0, 1);
    check("t2_prelock", 32'(dll.iodll_lock), 32'd0);
    drive(1'b1, 5'h00, 1'b1, 1'b0, 1);
    check("t2_lock", 32'(dll.iodll_lock), 32'd1);
    check("t2_code", 32'(dll.lpf_out), 32'h10);
    drive(1'b1, 5'h00, 1'b1, 1'b1, 7);
    check("t3_lock_hold", 32'(dll.iodll_lock), 32'd1);
    check("t3_code1", 32'(dll.lpf_out), 32'h11);
    drive(1'b1, 5'h00, 1'b1, 1'b1, 15);
    check("t3_lock_drop", 32'(dll.iodll_lock), 32'd0);
    check("t3_code2", 32'(dll.lpf_out), 32'h12);
    apply_reset("t3_end");

    // Bypass from locked: load codes with 1-cycle latency, then resume tracking from 1C
    alt_to_lock();
    check("t5_locked", 32'(dll.iodll_lock), 32'd1);
    drive(1'b0, 5'h03, 1'b1, 1'b1, 1);
    check("t5_byp03", 32'(dll.lpf_out), 32'h03);
    check("t5_stb03", 32'(dll.strobe), 32'd1);
    check("t5_unlock", 32'(dll.iodll_lock), 32'd0);
    drive(1'b0, 5'h1C, 1'b1, 1'b1, 1);
    check("t5_byp1c", 32'(dll.lpf_out), 32'h1C);
    check("t5_stb1c", 32'(dll.strobe), 32'd1);
    drive(1'b0, 5'h1C, 1'b1, 1'b1, 1);
    check("t5_stb_same", 32'(dll.strobe), 32'd0);
    drive(1'b1, 5'h00, 1'b1, 1'b1, 15);
    check("t5_hold1c", 32'(dll.lpf_out), 32'h1C);
    drive(1'b1, 5'h00, 1'b1, 1'b1, 1);
    check("t5_track1d", 32'(dll.lpf_out), 32'h1D);

    // Reset mid-settling and while locked
    apply_reset("t5_end");
    drive(1'b1, 5'h00, 1'b1, 1'b1, 3);
    apply_reset("mid_settle");
    alt_to_lock();
    check("t6_locked", 32'(dll.iodll_lock), 32'd1);
    apply_reset("while_locked");

    // Saturate upward, then downward
    drive(1'b1, 5'h00, 1'b1, 1'b1, 240);
    check("t4_top", 32'(dll.lpf_out), 32'h1F);
    check("t4_ovf_up", 32'(dll.overflow), 32'd1);
    drive(1'b1, 5'h00, 1'b1, 1'b1, 20);
    check("t4_ovf_sticky", 32'(dll.overflow), 32'd1);
    apply_reset("t4_up_end");
    drive(1'b1, 5'h00, 1'b1, 1'b0, 271);
    check("t4_ovf_pre", 32'(dll.overflow), 32'd0);
    drive(1'b1, 5'h00, 1'b1, 1'b0, 1);
    check("t4_bottom", 32'(dll.lpf_out), 32'h00);
    check("t4_ovf_dn", 32'(dll.overflow), 32'd1);
    drive(1'b0, 5'h05, 1'b1, 1'b0, 1);
    check("t4_ovf_byp", 32'(dll.overflow), 32'd1);
    check("t4_byp05", 32'(dll.lpf_out), 32'h05);
    apply_reset("t4_dn_end");

    // Random traffic with biased vote direction and occasional bypass bursts
    for (int blk = 0; blk < 8; blk++) begin
      int bias;
      bias = (blk % 2 == 0) ? 85 : 15;
      for (int i = 0; i < 50; i++) begin
        drive(($urandom_range(0, 19) != 0), 5'($urandom_range(0, 31)),
              ($urandom_range(0, 3) != 0), ($urandom_range(0, 99) < bias), 1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
